ifetch_queue: RTL and testbench

Instruction fetch queue that supplies the instruction decoder. It fetches aligned 32-bit words from the instruction memory port and buffers them as 16-bit halfwords. It presents a 32-bit instruction window (`istrWord`) with its PC, and consumes 2 or 4 bytes per decoded op as reported back by the decoder's `idStepPc`. It also handles branch redirects, and the 8Axx/8Exx 32-bit op forms, which must not be presented until both halfwords are buffered.

---
 rtl/ifetch_queue.sv | 188 ++++++++++++++++++
 tb/tb_ifetch_queue.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch queue feeding the decoder.
// Fetches aligned 32-bit words and buffers them as halfwords in a ring.
// Presents a registered 32-bit window (head, head+1) with its PC.
// Handles branch redirects, including a redirect that lands on an odd halfword.
// Holds back an 8Axx/8Exx prefix halfword until its second halfword is buffered.
module ifetch_queue #(
    parameter int          QHW      = 8,
    parameter logic [31:0] RESET_PC = 32'hA000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] memAddr,
    output logic        memReq,
    input  logic        memOK,
    input  logic [31:0] memData,
    output logic [31:0] istrWord,
    output logic [31:0] istrPc,
    output logic        istrValid,
    input  logic [3:0]  idStepPc,
    input  logic        idAdvance,
    input  logic        brTaken,
    input  logic [31:0] brTarget
);

    localparam int PTR_W = $clog2(QHW);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TWO = CNT_W'(2);

    // Halfword storage and queue state
    logic [15:0]       r_buf [QHW];
    logic [PTR_W-1:0]  r_head;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_fetch_addr;
    logic [31:0]       r_mem_addr;
    logic              r_mem_req;
    logic              r_skip_low;
    logic              r_discard;
    logic [31:0]       r_istr_pc;
    logic [31:0]       r_istr_word;
    logic              r_istr_valid;

    logic              w_accept;
    logic              w_push_en;
    logic              w_consume;
    logic [1:0]        w_pop;
    logic [1:0]        w_push_n;
    logic [PTR_W-1:0]  w_tail;
    logic [PTR_W-1:0]  w_tail1;
    logic [PTR_W-1:0]  w_hi_idx;
    logic [15:0]       w_buf_next [QHW];
    logic [CNT_W-1:0]  w_count_next;
    logic [PTR_W-1:0]  w_head_next;
    logic [PTR_W-1:0]  w_head_next1;
    logic [15:0]       w_head_hw;
    logic [15:0]       w_next_hw;
    logic              w_room;
    logic              w_valid_next;
    logic [31:0]       w_word_next;
    logic [31:0]       w_pc_next;
    logic [31:0]       w_fetch_addr_next;
    logic              w_mem_req_next;
    logic              w_skip_next;
    logic              w_discard_next;
    logic              w_unused;

    // Bit 0 of the branch target never matters: PCs are halfword aligned.
    assign w_unused = brTarget[0];

    // A redirect kills both the same-cycle consume and any arriving data.
    assign w_accept  = r_mem_req & memOK;
    assign w_push_en = w_accept & ~r_discard & ~brTaken;
    assign w_consume = idAdvance & r_istr_valid & ~brTaken;
    assign w_push_n  = w_push_en ? (r_skip_low ? 2'd1 : 2'd2) : 2'd0;

    // Number of halfwords popped by the decoder this cycle
    always_comb begin
        w_pop = 2'd0;
        if (w_consume) begin
            if (idStepPc == 4'd2) begin
                w_pop = 2'd1;
            end else if (idStepPc == 4'd4 && r_count >= C_TWO) begin
                w_pop = 2'd2;
            end
        end
    end

    // Write slots: low half at tail, high half right after it (or at tail when
    // the low half is skipped after an odd-halfword redirect).
    assign w_tail   = r_head + r_count[PTR_W-1:0];
    assign w_tail1  = w_tail + PTR_W'(1);
    assign w_hi_idx = r_skip_low ? w_tail : w_tail1;

    generate
        for (genvar gi = 0; gi < QHW; gi++) begin : g_slot
            assign w_buf_next[gi] =
                (w_push_en && !r_skip_low && w_tail == PTR_W'(gi)) ? memData[15:0]  :
                (w_push_en && w_hi_idx == PTR_W'(gi))              ? memData[31:16] :
                                                                      r_buf[gi];

            // Storage slot update (contents are don't-care while unoccupied)
            always_ff @(posedge clk) begin
                r_buf[gi] <= w_buf_next[gi];
            end
        end
    endgenerate

    assign w_count_next = brTaken ? '0 : (r_count + CNT_W'(w_push_n) - CNT_W'(w_pop));
    assign w_head_next  = brTaken ? r_head : (r_head + PTR_W'(w_pop));
    assign w_head_next1 = w_head_next + PTR_W'(1);
    assign w_room       = int'(w_count_next) <= QHW - 2;
    assign w_pc_next    = brTaken ? {brTarget[31:1], 1'b0}
                                  : (r_istr_pc + {29'd0, w_pop, 1'b0});

    // Window for the next cycle is built from post-update queue contents so
    // freshly pushed data is visible one cycle after memOK.
    assign w_head_hw = w_buf_next[w_head_next];
    assign w_next_hw = w_buf_next[w_head_next1];
    assign w_word_next = {(w_count_next >= C_TWO) ? w_next_hw : 16'h0000,
                          (w_count_next >= C_ONE) ? w_head_hw : 16'h0000};
    assign w_valid_next = (w_count_next >= C_TWO) ||
                          (w_count_next == C_ONE &&
                           w_head_hw[15:8] != 8'h8A && w_head_hw[15:8] != 8'h8E);

    // Fetch request control: redirect, completion, and idle re-arm
    always_comb begin
        w_fetch_addr_next = r_fetch_addr;
        w_mem_req_next    = r_mem_req;
        w_skip_next       = r_skip_low;
        w_discard_next    = r_discard;
        if (brTaken) begin
            w_fetch_addr_next = {brTarget[31:2], 2'b00};
            w_skip_next       = brTarget[1];
            if (r_mem_req && !memOK) begin
                // Old request must still finish at its old address.
                w_discard_next = 1'b1;
            end else begin
                w_discard_next = 1'b0;
                w_mem_req_next = 1'b1;
            end
        end else if (w_accept) begin
            if (r_discard) begin
                w_discard_next = 1'b0;
                w_mem_req_next = 1'b0;
            end else begin
                w_fetch_addr_next = r_fetch_addr + 32'd4;
                w_skip_next       = 1'b0;
                w_mem_req_next    = w_room;
            end
        end else if (!r_mem_req) begin
            w_mem_req_next = !r_discard && w_room;
        end
    end

    // Control state and registered decoder-facing outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head       <= '0;
            r_count      <= '0;
            r_fetch_addr <= {RESET_PC[31:2], 2'b00};
            r_mem_addr   <= {RESET_PC[31:2], 2'b00};
            r_mem_req    <= 1'b0;
            r_skip_low   <= RESET_PC[1];
            r_discard    <= 1'b0;
            r_istr_pc    <= RESET_PC;
            r_istr_word  <= 32'd0;
            r_istr_valid <= 1'b0;
        end else begin
            r_head       <= w_head_next;
            r_count      <= w_count_next;
            r_fetch_addr <= w_fetch_addr_next;
            r_mem_addr   <= w_discard_next ? r_mem_addr : w_fetch_addr_next;
            r_mem_req    <= w_mem_req_next;
            r_skip_low   <= w_skip_next;
            r_discard    <= w_discard_next;
            r_istr_pc    <= w_pc_next;
            r_istr_word  <= w_word_next;
            r_istr_valid <= w_valid_next;
        end
    end

    assign memAddr   = r_mem_addr;
    assign memReq    = r_mem_req;
    assign istrWord  = r_istr_word;
    assign istrPc    = r_istr_pc;
    assign istrValid = r_istr_valid;

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based reference model of the fetch queue.
module tb_ifetch_queue;

    localparam int          QHW      = 8;
    localparam logic [31:0] RESET_PC = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] memAddr;
    logic        memReq;
    logic        memOK = 1'b0;
    logic [31:0] memData = 32'd0;
    logic [31:0] istrWord;
    logic [31:0] istrPc;
    logic        istrValid;
    logic [3:0]  idStepPc = 4'd0;
    logic        idAdvance = 1'b0;
    logic        brTaken = 1'b0;
    logic [31:0] brTarget = 32'd0;

    always #5 clk = ~clk;

    ifetch_queue #(.QHW(QHW), .RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .memAddr   (memAddr),
        .memReq    (memReq),
        .memOK     (memOK),
        .memData   (memData),
        .istrWord  (istrWord),
        .istrPc    (istrPc),
        .istrValid (istrValid),
        .idStepPc  (idStepPc),
        .idAdvance (idAdvance),
        .brTaken   (brTaken),
        .brTarget  (brTarget)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory contents: a few fixed words for the directed scenarios, the rest
    // from a random table seeded with prefix halfwords.
    logic [31:0] mem_tbl [64];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'hA000_0000: return 32'h2001_E005;
            32'h0000_1000: return 32'h8E12_3456;
            32'h0000_1004: return 32'h7777_C0DE;
            32'h0000_2004: return 32'hBBBB_AAAA;
            default:       return mem_tbl[a[7:2]];
        endcase
    endfunction

    // Memory responder state
    bit          pend = 1'b0;
    int          lat = 0;
    int          fix_lat = -1;
    int          max_lat = 0;
    logic [31:0] slow_addr = 32'hFFFF_FFFF;
    int          slow_lat = 0;
    int          n_words = 0;

    task automatic drive_mem();
        if (memReq) begin
            if (!pend) begin
                pend = 1'b1;
                if (memAddr == slow_addr)  lat = slow_lat;
                else if (fix_lat >= 0)     lat = fix_lat;
                else                       lat = $urandom_range(max_lat, 0);
            end
            if (lat == 0) begin
                memOK   = 1'b1;
                memData = mem_word(memAddr);
                pend    = 1'b0;
                n_words++;
            end else begin
                memOK   = 1'b0;
                memData = $urandom;
                lat--;
            end
        end else begin
            pend    = 1'b0;
            memOK   = 1'($urandom_range(1, 0));
            memData = $urandom;
        end
    endtask

    // Reference model: halfword queue plus fetch bookkeeping
    logic [15:0] hq[$];
    logic [31:0] m_pc, m_faddr, m_raddr;
    bit          m_skip, m_disc, m_req;

    function automatic bit is_prefix(input logic [15:0] h);
        return h[15:8] == 8'h8A || h[15:8] == 8'h8E;
    endfunction

    function automatic bit m_valid();
        return hq.size() >= 2 || (hq.size() == 1 && !is_prefix(hq[0]));
    endfunction

    function automatic logic [31:0] m_word();
        logic [15:0] lo = 16'h0000;
        logic [15:0] hi = 16'h0000;
        if (hq.size() >= 1) lo = hq[0];
        if (hq.size() >= 2) hi = hq[1];
        return {hi, lo};
    endfunction

    task automatic model_reset();
        hq.delete();
        m_pc    = RESET_PC;
        m_faddr = RESET_PC & ~32'd3;
        m_raddr = m_faddr;
        m_skip  = RESET_PC[1];
        m_disc  = 1'b0;
        m_req   = 1'b0;
    endtask

    task automatic model_step();
        bit          acc = m_req && memOK;
        bit          vld = m_valid();
        logic [31:0] w;
        if (brTaken) begin
            hq.delete();
            m_pc    = {brTarget[31:1], 1'b0};
            m_faddr = {brTarget[31:2], 2'b00};
            m_skip  = brTarget[1];
            if (m_req && !memOK) begin
                m_disc = 1'b1;
            end else begin
                m_disc  = 1'b0;
                m_req   = 1'b1;
                m_raddr = m_faddr;
            end
        end else begin
            if (idAdvance && vld) begin
                if (idStepPc == 4'd2) begin
                    void'(hq.pop_front());
                    m_pc += 2;
                end else if (idStepPc == 4'd4 && hq.size() >= 2) begin
                    void'(hq.pop_front());
                    void'(hq.pop_front());
                    m_pc += 4;
                end
            end
            if (acc) begin
                if (m_disc) begin
                    m_disc = 1'b0;
                    m_req  = 1'b0;
                end else begin
                    w = mem_word(m_raddr);
                    if (!m_skip) hq.push_back(w[15:0]);
                    hq.push_back(w[31:16]);
                    m_skip  = 1'b0;
                    m_faddr = m_faddr + 32'd4;
                    m_req   = (hq.size() + 2 <= QHW);
                    if (m_req) m_raddr = m_faddr;
                end
            end else if (!m_req && hq.size() + 2 <= QHW) begin
                m_req   = 1'b1;
                m_raddr = m_faddr;
            end
        end
    endtask

    // One clock: compare outputs to the model, answer memory, advance model.
    task automatic tick();
        @(negedge clk);
        chk("memReq", {31'd0, memReq}, {31'd0, m_req});
        if (m_req) chk("memAddr", memAddr, m_raddr);
        chk("istrValid", {31'd0, istrValid}, {31'd0, m_valid()});
        chk("istrWord", istrWord, m_word());
        chk("istrPc", istrPc, m_pc);
        drive_mem();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_memReq"}, {31'd0, memReq}, 32'd0);
        chk({tag, "_memAddr"}, memAddr, RESET_PC & ~32'd3);
        chk({tag, "_valid"}, {31'd0, istrValid}, 32'd0);
        chk({tag, "_word"}, istrWord, 32'd0);
        chk({tag, "_pc"}, istrPc, RESET_PC);
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        memOK   = 1'b0;
        brTaken = 1'b0;
        pend    = 1'b0;
        model_reset();
        #1;
        reset_checks("midrst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int gap;
        int r;
        int adv_pct;
        logic [31:0] w;

        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            if ($urandom_range(3, 0) == 0) w[15:8]  = ($urandom_range(1, 0) != 0) ? 8'h8A : 8'h8E;
            if ($urandom_range(3, 0) == 0) w[31:24] = ($urandom_range(1, 0) != 0) ? 8'h8A : 8'h8E;
            mem_tbl[i] = w;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst");
        reset_n = 1'b1;

        // Reset fetch, then sleep until the queue fills and fetching stalls
        max_lat   = 0;
        idAdvance = 1'b1;
        idStepPc  = 4'd0;
        tick();
        chk("s1_req", {31'd0, memReq}, 32'd1);
        chk("s1_addr", memAddr, 32'hA000_0000);
        tick();
        chk("s1_valid", {31'd0, istrValid}, 32'd1);
        chk("s1_word", istrWord, 32'h2001_E005);
        chk("s1_pc", istrPc, 32'hA000_0000);
        $display("scenario reset_fetch done");
        repeat (10) tick();
        chk("s4_words", n_words, 32'd4);
        chk("s4_req", {31'd0, memReq}, 32'd0);
        chk("s6_pc", istrPc, 32'hA000_0000);
        chk("s6_valid", {31'd0, istrValid}, 32'd1);
        chk("s6_word", istrWord, 32'h2001_E005);
        idStepPc = 4'd4;
        tick();
        idAdvance = 1'b0;
        chk("s4_reissue", {31'd0, memReq}, 32'd1);
        chk("s4_pc", istrPc, 32'hA000_0004);
        $display("scenario full_stall_sleep done");

        // Redirect onto the second half of an 8Exx prefix op
        slow_addr = 32'h0000_1004;
        slow_lat  = 5;
        brTarget  = 32'h0000_1002;
        brTaken   = 1'b1;
        tick();
        brTaken = 1'b0;
        tick();
        tick();
        chk("s2_hold", {31'd0, istrValid}, 32'd0);
        chk("s2_partial", istrWord, 32'h0000_8E12);
        chk("s2_pc", istrPc, 32'h0000_1002);
        for (int i = 0; i < 20 && istrValid !== 1'b1; i++) tick();
        chk("s2_valid", {31'd0, istrValid}, 32'd1);
        chk("s2_word", istrWord, 32'hC0DE_8E12);
        idAdvance = 1'b1;
        idStepPc  = 4'd4;
        tick();
        idAdvance = 1'b0;
        chk("s2_step4", istrPc, 32'h0000_1006);
        slow_addr = 32'hFFFF_FFFF;
        $display("scenario prefix_hold done");

        // Odd-halfword redirect
        brTarget = 32'h0000_2006;
        brTaken  = 1'b1;
        tick();
        brTaken = 1'b0;
        tick();
        chk("s3_word", istrWord, 32'h0000_BBBB);
        chk("s3_valid", {31'd0, istrValid}, 32'd1);
        chk("s3_pc", istrPc, 32'h0000_2006);
        chk("s3_req", {31'd0, memReq}, 32'd1);
        chk("s3_addr", memAddr, 32'h0000_2008);
        $display("scenario odd_redirect done");

        // Redirect in cycle 3 of a 6-cycle access
        brTarget = 32'h0000_3000;
        brTaken  = 1'b1;
        tick();
        brTaken = 1'b0;
        fix_lat = 5;
        tick();
        tick();
        fix_lat  = 0;
        brTarget = 32'h0000_4000;
        brTaken  = 1'b1;
        tick();
        brTaken = 1'b0;
        gap = 0;
        for (int i = 0; i < 30 && istrValid !== 1'b1; i++) begin
            tick();
            if (!memReq) gap++;
        end
        chk("s5_gap", gap, 32'd1);
        chk("s5_valid", {31'd0, istrValid}, 32'd1);
        chk("s5_pc", istrPc, 32'h0000_4000);
        chk("s5_word", istrWord, mem_word(32'h0000_4000));
        $display("scenario redirect_outstanding done");

        // Randomized traffic with one asynchronous reset in the middle
        fix_lat = -1;
        max_lat = 3;
        adv_pct = 75;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) begin
                max_lat = $urandom_range(6, 0);
                adv_pct = $urandom_range(100, 10);
            end
            idAdvance = ($urandom_range(99, 0) < adv_pct);
            r = $urandom_range(9, 0);
            idStepPc = (r < 4) ? 4'd2 : (r < 8) ? 4'd4 : (r == 8) ? 4'd0 : 4'($urandom_range(15, 0));
            brTaken  = ($urandom_range(99, 0) < 3);
            brTarget = ($urandom_range(19, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0)))
                                                    : (32'h0000_1000 + 32'($urandom_range(255, 0)));
            if (c == 2000) do_reset();
            else           tick();
        end
        brTaken   = 1'b0;
        idAdvance = 1'b0;
        $display("scenario random done");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
